// File: rtl/fir_src_pkg.sv
// Shared encodings and LFSR helpers for fir_sample_source.
// The LFSR constants are used only when FIR_SRC_LFSR_EN is defined.
package fir_src_pkg;

    localparam logic [1:0] MODE_RAMP    = 2'd0;
    localparam logic [1:0] MODE_IMPULSE = 2'd1;
    localparam logic [1:0] MODE_STEP    = 2'd2;
    localparam logic [1:0] MODE_LFSR    = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Polynomial taps 16,14,13,11 expressed as bit indices of the right-shifting register.
    localparam int unsigned LFSR_TAP_16 = 0;
    localparam int unsigned LFSR_TAP_14 = 2;
    localparam int unsigned LFSR_TAP_13 = 3;
    localparam int unsigned LFSR_TAP_11 = 5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[LFSR_TAP_16] ^ l[LFSR_TAP_14] ^ l[LFSR_TAP_13] ^ l[LFSR_TAP_11];
        return {fb, l[15:1]};
    endfunction

endpackage

// File: rtl/fir_src_lfsr.sv
// 16-bit Fibonacci LFSR with seed load and advance enable.
// Only built when FIR_SRC_LFSR_EN is defined.
`ifdef FIR_SRC_LFSR_EN
module fir_src_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic        advance,
    output logic [15:0] state
);
    import fir_src_pkg::*;

    logic [15:0] lfsr_d, lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = LFSR_SEED;
        end else if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule
`endif

// File: rtl/fir_sample_source.sv
// Burst sample generator (ramp/impulse/step/LFSR) feeding FIR din over valid/ready.
// Define FIR_SRC_LFSR_EN to build the pseudo-random mode; otherwise mode 3 emits zeros.
module fir_sample_source #(
    parameter int unsigned DW       = 5,
    parameter int unsigned RAMP_MAX = 9,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] length,
    input  logic [DW-1:0]    amp,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done
);
    import fir_src_pkg::*;

    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    RampTop = DW'(RAMP_MAX);
    localparam logic [DW-1:0]    RampOne = {{(DW-1){1'b0}}, 1'b1};

    state_e           state_d, state_q;
    logic [1:0]       mode_d, mode_q;
    logic [CNT_W-1:0] len_d, len_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [DW-1:0]    amp_d, amp_q;
    logic [DW-1:0]    ramp_d, ramp_q;
    logic             first_d, first_q;
    logic             xfer;
    logic             accept;

    assign xfer   = (state_q == StRun) && dout_ready;
    assign accept = (state_q == StIdle) && start;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        amp_d   = amp_q;
        ramp_d  = ramp_q;
        first_d = first_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode;
                    len_d   = length;
                    amp_d   = amp;
                    cnt_d   = '0;
                    ramp_d  = '0;
                    first_d = 1'b1;
                    state_d = (length == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // Every generator register advances only on an accepted transfer.
                if (xfer) begin
                    cnt_d   = cnt_q + CntOne;
                    ramp_d  = (ramp_q >= RampTop) ? '0 : ramp_q + RampOne;
                    first_d = 1'b0;
                    if (cnt_q == len_q - CntOne) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= MODE_RAMP;
            len_q   <= '0;
            cnt_q   <= '0;
            amp_q   <= '0;
            ramp_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            amp_q   <= amp_d;
            ramp_q  <= ramp_d;
            first_q <= first_d;
        end
    end

`ifdef FIR_SRC_LFSR_EN
    logic [15:0] lfsr_state;

    fir_src_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (accept),
        .advance   (xfer),
        .state     (lfsr_state)
    );
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    // dout is forced to 0 outside RUN so idle/done cycles never show stale data.
    always_comb begin
        dout = '0;
        if (state_q == StRun) begin
            case (mode_q)
                MODE_RAMP:    dout = ramp_q;
                MODE_IMPULSE: dout = first_q ? amp_q : '0;
                MODE_STEP:    dout = amp_q;
`ifdef FIR_SRC_LFSR_EN
                MODE_LFSR:    dout = lfsr_state[DW-1:0];
`else
                MODE_LFSR:    dout = '0;
`endif
                default:      dout = '0;
            endcase
        end
    end

    assign dout_valid = (state_q == StRun);
    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_fir_sample_source.sv
// Directed bench for fir_sample_source; expected samples are queued when a burst is
// started and popped on every observed transfer. Honours FIR_SRC_LFSR_EN like the DUT.
module tb_fir_sample_source;

    localparam int DW       = 5;
    localparam int RAMP_MAX = 9;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] length;
    logic [DW-1:0]    amp;
    logic [DW-1:0]    dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;
    int n_xfer = 0;
    logic [DW-1:0] exp_q[$];

    fir_sample_source #(
        .DW       (DW),
        .RAMP_MAX (RAMP_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .length     (length),
        .amp        (amp),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Score any transfer that the coming edge will perform, then advance one cycle.
    task automatic tick();
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                check("dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_burst(input logic [1:0] m, input int len, input logic [DW-1:0] a);
        mode   = m;
        length = CNT_W'(len);
        amp    = a;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        // Later input changes must not disturb the captured burst.
        mode   = ~m;
        amp    = ~a;
        length = CNT_W'(len + 7);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst        = 1'b1;
        start      = 1'b0;
        mode       = 2'd0;
        length     = '0;
        amp        = '0;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_dout", 32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        tick();

        // 1: ramp of 12 at full throughput wraps after RAMP_MAX.
        for (int i = 0; i < 12; i++) exp_q.push_back(DW'(i % (RAMP_MAX + 1)));
        base = n_xfer;
        begin_burst(2'd0, 12, 5'd0);
        check("t1_valid", 32'(dout_valid), 1);
        check("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 12; i++) tick();
        check("t1_done", 32'(done), 1);
        check("t1_busy_at_done", 32'(busy), 0);
        check("t1_valid_at_done", 32'(dout_valid), 0);
        check("t1_xfers", 32'(n_xfer - base), 12);
        tick();
        check("t1_done_one_cycle", 32'(done), 0);

        // 2: step with a two-cycle stall on the second sample.
        for (int i = 0; i < 3; i++) exp_q.push_back(5'd5);
        base = n_xfer;
        begin_burst(2'd2, 3, 5'd5);
        tick();
        dout_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t2_stall_valid", 32'(dout_valid), 1);
            check("t2_stall_hold", 32'(dout), 5);
            tick();
        end
        dout_ready = 1'b1;
        tick();
        tick();
        check("t2_done", 32'(done), 1);
        check("t2_xfers", 32'(n_xfer - base), 3);
        tick();

        // 3: impulse; busy covers every transfer and drops with done.
        exp_q.push_back(5'd7);
        for (int i = 0; i < 3; i++) exp_q.push_back(5'd0);
        begin_burst(2'd1, 4, 5'd7);
        for (int i = 0; i < 4; i++) begin
            check("t3_busy", 32'(busy), 1);
            tick();
        end
        check("t3_done", 32'(done), 1);
        check("t3_busy_at_done", 32'(busy), 0);
        tick();

        // 4: empty burst; start during the done pulse is dropped.
        base = n_xfer;
        begin_burst(2'd0, 0, 5'd0);
        check("t4_valid", 32'(dout_valid), 0);
        check("t4_done", 32'(done), 1);
        check("t4_busy", 32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_idle_done", 32'(done), 0);
        check("t4_idle_busy", 32'(busy), 0);
        tick();
        check("t4_not_queued_busy", 32'(busy), 0);
        check("t4_not_queued_valid", 32'(dout_valid), 0);
        check("t4_not_queued_done", 32'(done), 0);
        check("t4_xfers", 32'(n_xfer - base), 0);

        // 5: reset part way through a long ramp, then restart.
        for (int i = 0; i < 20; i++) exp_q.push_back(DW'(i % (RAMP_MAX + 1)));
        begin_burst(2'd0, 100, 5'd0);
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_rst_dout", 32'(dout), 0);
        check("t5_rst_valid", 32'(dout_valid), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_done", 32'(done), 0);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(DW'(i));
        begin_burst(2'd0, 3, 5'd0);
        wait_done("t5_restart_done", 10);
        tick();

        // 6: mode 3 yields LFSR low bits or zeros depending on the build.
`ifdef FIR_SRC_LFSR_EN
        exp_q.push_back(5'h01);
        exp_q.push_back(5'h10);
`else
        exp_q.push_back(5'h00);
        exp_q.push_back(5'h00);
`endif
        begin_burst(2'd3, 2, 5'd0);
        wait_done("t6_done", 10);
        tick();

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
